// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// STATUS bit positions and default register word indices.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVERFLOW = 3;

    localparam logic [31:0] DEFAULT_TX_DATA_IDX = 32'h0000_0400;
    localparam logic [31:0] DEFAULT_STATUS_IDX  = 32'h0000_0401;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO queueing bytes for the transmitter. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    // NOTE: storage has no reset; count/pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_DATA_IDX queue bytes in a
// 4-entry FIFO, STATUS_IDX reports {overflow, full, empty, busy}.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int               LENGTH       = 32,
    parameter int               CLKS_PER_BIT = 434,
    parameter logic [LENGTH-1:0] TX_DATA_IDX = LENGTH'(DEFAULT_TX_DATA_IDX),
    parameter logic [LENGTH-1:0] STATUS_IDX  = LENGTH'(DEFAULT_STATUS_IDX)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LENGTH-1:0] addr_idx,
    input  logic              wr_en,
    input  logic [LENGTH-1:0] wr_data,
    output logic [LENGTH-1:0] rd_data,
    output logic              hit,
    output logic              tx
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t      state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           overflow;

    logic [7:0]     head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2:0]     fifo_count;

    logic           sel_tx;
    logic           sel_status;
    logic           push_req;
    logic           pop;
    logic           drop;
    logic           clr_ovf;
    logic           busy;
    logic           bit_done;
    logic           unused_bits;

    assign sel_tx     = (addr_idx == TX_DATA_IDX);
    assign sel_status = (addr_idx == STATUS_IDX);
    assign hit        = sel_tx | sel_status;

    assign push_req = wr_en && sel_tx;
    assign pop      = (state == IDLE) && !fifo_empty;
    assign drop     = push_req && fifo_full && !pop;
    assign clr_ovf  = wr_en && sel_status && wr_data[STAT_OVERFLOW];
    assign busy     = (state != IDLE);
    assign bit_done = (clk_cnt == CNT_LAST);

    assign unused_bits = ^{wr_data[LENGTH-1:8], fifo_count};

    // NOTE: rd_data gets a default before the decode so no latch is inferred.
    always_comb begin
        rd_data = '0;
        if (sel_status) begin
            rd_data[STAT_BUSY]     = busy;
            rd_data[STAT_EMPTY]    = fifo_empty;
            rd_data[STAT_FULL]     = fifo_full;
            rd_data[STAT_OVERFLOW] = overflow;
        end
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (wr_data[7:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= head;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_done) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (bit_done) begin
                        clk_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
